// File: rtl/gray_rd_arbiter_if.sv
// Engine-side bus of the gray-image read arbiter: per-engine requests,
// burst-lock hints, addresses and done flags in; grants, read-data valid
// and shared read data out.
interface gray_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        eng_done;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  // Pixel engines drive requests and consume grants and read data.
  modport master (
    output req, lock, addr, eng_done,
    input  gnt, rvalid, rdata
  );

  // The arbiter accepts requests and returns grants and read data.
  modport slave (
    input  req, lock, addr, eng_done,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/gray_rd_arbiter.sv
// Shares one gray-image read port between NUM_REQ pixel engines.
// Round-robin arbitration with a bounded burst lock, so an engine can fetch
// a 3x3 neighbourhood back to back. Read data returns two cycles after the
// grant, tagged to the requester. The per-engine done flags combine into a
// sticky finish.
module gray_rd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  gray_rd_arbiter_if.slave  eng,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [DATA_W-1:0] gray_data,
  output logic              finish
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {WAIT_READY, ARB, DONE} state_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q;
  logic               owner_vld_q;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               grant_any;
  logic               lock_cont;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   tag_q;
  logic [NUM_REQ-1:0] tag_onehot;

  // Next state and grant selection: locked continuation first, else round-robin.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    grant_any = 1'b0;
    grant_idx = '0;
    lock_cont = 1'b0;
    gnt_d     = '0;
    unique case (state_q)
      WAIT_READY: begin
        if (gray_ready || ready_q) state_d = ARB;
      end
      ARB: begin
        lock_cont = (NUM_REQ > 1) && owner_vld_q && eng.req[owner_q] &&
                    eng.lock[owner_q] && (burst_q < CNT_W'(MAX_BURST));
        if (lock_cont) begin
          grant_any = 1'b1;
          grant_idx = owner_q;
          burst_d   = burst_q + 1'b1;
        end else begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && eng.req[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
              grant_any = 1'b1;
              grant_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
          end
          if (grant_any) begin
            burst_d = CNT_W'(1);
            ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          end
        end
        if (grant_any) gnt_d[grant_idx] = 1'b1;
        if (&eng.eng_done) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = WAIT_READY;
      end
    endcase
  end

  // The grant is combinational; keep it quiet while reset is applied.
  assign eng.gnt    = reset ? '0 : gnt_d;
  assign tag_onehot = NUM_REQ'(1) << tag_q;

  // Arbitration bookkeeping: state, ready flag, pointer, owner, burst count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= WAIT_READY;
      ready_q     <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_q | gray_ready;
      ptr_q       <= ptr_d;
      owner_vld_q <= grant_any;
      burst_q     <= burst_d;
      if (grant_any) owner_q <= grant_idx;
    end
  end

  // Read pipeline: address stage, then data return tagged to the requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      gray_addr  <= '0;
      gray_req   <= 1'b0;
      tag_q      <= '0;
      eng.rvalid <= '0;
      eng.rdata  <= '0;
      finish     <= 1'b0;
    end else begin
      gray_req <= grant_any;
      if (grant_any) begin
        gray_addr <= eng.addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        tag_q     <= grant_idx;
      end
      eng.rvalid <= gray_req ? tag_onehot : '0;
      if (gray_req) eng.rdata <= gray_data;
      finish <= finish | (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Directed bench for gray_rd_arbiter: a table of start-up and alternation
// vectors, then hand-written sequences for burst lock, lock release,
// single requester, done handling and reset in mid-operation.
module tb_gray_rd_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              gray_ready;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic [DATA_W-1:0] gray_data;
  logic              finish;

  gray_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) eng ();

  gray_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gray_ready(gray_ready),
    .eng(eng),
    .gray_addr(gray_addr),
    .gray_req(gray_req),
    .gray_data(gray_data),
    .finish(finish)
  );

  always #5 clk = ~clk;

  // Image memory: pixel value is a fixed scramble of the address.
  function automatic logic [7:0] mem_f(input logic [13:0] a);
    return (a[7:0] ^ {2'b00, a[13:8]}) + 8'd3;
  endfunction

  assign gray_data = mem_f(gray_addr);

  int errors = 0;
  int checks = 0;

  logic [13:0] addr0, addr1;
  // Expected grants one and two cycles back, with their addresses.
  logic [1:0]  h1_g, h2_g;
  logic [13:0] h1_a, h2_a;
  logic [7:0]  rd_exp;

  typedef struct {
    logic       rst;
    logic       gr;
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] done;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rvalid;
    logic       exp_greq;
    logic       exp_fin;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare 1 ns later, advance model.
  task automatic step(input logic rst, input logic gr, input logic [1:0] rq,
                      input logic [1:0] lk, input logic [1:0] dn,
                      input logic [1:0] exp_gnt, input logic exp_fin,
                      input string tag);
    @(negedge clk);
    reset          = rst;
    gray_ready     = gr;
    eng.req        = rq;
    eng.lock       = lk;
    eng.eng_done   = dn;
    eng.addr       = {addr1, addr0};
    #1;
    check({tag, " gnt"}, eng.gnt, exp_gnt);
    check({tag, " rvalid"}, eng.rvalid, h2_g);
    check({tag, " gray_req"}, gray_req, |h1_g);
    if (|h1_g) check({tag, " gray_addr"}, gray_addr, h1_a);
    if (|h2_g) rd_exp = mem_f(h2_a);
    check({tag, " rdata"}, eng.rdata, rd_exp);
    check({tag, " finish"}, finish, exp_fin);
    if (rst) begin
      h1_g = 2'b00; h2_g = 2'b00; rd_exp = 8'h00;
    end else begin
      h2_g = h1_g; h2_a = h1_a;
      h1_g = exp_gnt;
      h1_a = exp_gnt[0] ? addr0 : addr1;
    end
  endtask

  initial begin
    reset = 1'b1; gray_ready = 1'b0;
    eng.req = '0; eng.lock = '0; eng.eng_done = '0;
    addr0 = 14'd129; addr1 = 14'd8321;
    eng.addr = {addr1, addr0};
    h1_g = 2'b00; h2_g = 2'b00; h1_a = '0; h2_a = '0; rd_exp = 8'h00;

    //             rst  gr    req    lock   done   gnt    rvalid greq  fin
    tbl[0]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    repeat (2) @(negedge clk);

    // Start-up wait for gray_ready, then plain round-robin alternation.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].gr, tbl[i].req, tbl[i].lock, tbl[i].done,
           tbl[i].exp_gnt, tbl[i].exp_fin, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_rvalid", i), eng.rvalid, tbl[i].exp_rvalid);
      check($sformatf("vec%0d tbl_gray_req", i), gray_req, tbl[i].exp_greq);
    end

    // Burst lock: engine0 locked for 12 cycles while engine1 requests.
    for (int c = 1; c <= 12; c++) begin
      addr0 = 14'd129 + 14'(c);
      step(1'b0, 1'b0, 2'b11, 2'b01, 2'b00,
           (c == 10) ? 2'b10 : 2'b01, 1'b0, $sformatf("burst%0d", c));
    end
    addr0 = 14'd129;

    // Only engine1 requests, then requests stop.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, "solo1");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "solo_idle_a");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "solo_idle_b");

    // Engine0 drops its lock after four grants: engine1 gets the next one.
    for (int c = 1; c <= 4; c++)
      step(1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 1'b0, $sformatf("lockdrop%0d", c));
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, "lockdrop5");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, "lockdrop6");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "lockdrop_idle_a");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "lockdrop_idle_b");

    // Done handling: reads granted just before DONE still complete.
    step(1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0, "done1");
    step(1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b01, 1'b0, "done2");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, "done3");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, "done4");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, "done5");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "done6");

    // Reset the cycle after a grant: read discarded, pointer back to 0.
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "rst1");
    step(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "rst2");
    step(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, "rst3");
    step(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "rst4");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "rst5");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "rst6");
    step(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "rst7");
    step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, "rst8");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "rst9");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "rst10");
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "rst11");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
